hyper_mvblck_todram_gen: RTL and testbench

HYPER_MVBLCK_TODRAM_GEN -- requirements
Module: hyper_mvblck_todram_gen

---
 rtl/hyper_mvblck_todram_gen.sv | 190 +++++++++++++++++++
 tb/tb_hyper_mvblck_todram_gen.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyper_mvblck_todram_gen.sv
// ============================================================================
// hyper_mvblck_todram_gen : moves words from a selected LSAB section into
// BEAT-aligned MCU write requests. Optional macro: HYPER_MVBLCK_STALL_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hyper_mvblck_todram_gen #(
    parameter  int ADDR_W      = 12,
    parameter  int CNT_W       = 5,
    parameter  int NSECT       = 4,
    parameter  int BEAT        = 2,
    parameter  int STALL_LIMIT = 8,
    localparam int SECT_W      = (NSECT > 1) ? $clog2(NSECT) : 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NSECT-1:0]    LSAB_EMPTY,
    output logic                LSAB_READ,
    output logic [SECT_W-1:0]   LSAB_SECTION,
    input  logic [ADDR_W-1:0]   START_ADDRESS,
    input  logic [CNT_W-1:0]    COUNT_REQ,
    input  logic [SECT_W-1:0]   SECTION,
    input  logic                ISSUE,
    output logic [CNT_W-1:0]    COUNT_SENT,
    output logic                WORKING,
    output logic                DONE,
    output logic [ADDR_W-1:0]   MCU_COLL_ADDRESS,
    output logic [2*BEAT-1:0]   MCU_WE_ARRAY,
    output logic                MCU_REQUEST_ACCESS
);

    localparam logic [ADDR_W-1:0] c_LOW_MASK = ADDR_W'(BEAT - 1);
    localparam logic [2*BEAT-1:0] c_TOP_SLOT = (2*BEAT)'(3) << (2*BEAT - 2);

`ifdef HYPER_MVBLCK_STALL_EN
    localparam int STALL_CW = $clog2(STALL_LIMIT + 1);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_STALL} state_t;
    logic [STALL_CW-1:0] r_stall;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;
`endif

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [CNT_W-1:0]    r_len, r_cnt_req, r_count_sent;
    logic [SECT_W-1:0]   r_sect;
    logic [2*BEAT-1:0]   r_mask, r_b_we, r_out_we;
    logic [ADDR_W-1:0]   r_b_addr, r_out_addr;
    logic                r_b_vld, r_req, r_read, r_working, r_done;
    logic [1:0]          r_fl;

    logic                w_sel_empty, w_accept, w_latch, w_flush_emit, w_done, w_close;
    logic [ADDR_W-1:0]   w_slot, w_base;
    logic [2*BEAT-1:0]   w_slot_bits, w_mask_nxt;

    assign w_sel_empty = LSAB_EMPTY[r_sect];
    assign w_slot      = r_addr & c_LOW_MASK;
    assign w_base      = r_addr & ~c_LOW_MASK;
    assign w_slot_bits = c_TOP_SLOT >> {w_slot, 1'b0};
    assign w_mask_nxt  = r_mask | w_slot_bits;
    // Beat ends on its last slot, on the last word, or when the address wraps.
    assign w_close     = (w_slot == c_LOW_MASK) || (r_len == CNT_W'(1)) || (r_addr == '1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_latch      = 1'b0;
        w_flush_emit = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ISSUE) begin
                    w_latch     = 1'b1;
                    w_state_nxt = (COUNT_REQ == '0) ? S_FLUSH : S_RUN;
                end
            end
            S_RUN: begin
                if (r_len == '0) begin
                    w_state_nxt = S_FLUSH;
                end else if (!w_sel_empty) begin
                    w_accept = 1'b1;
                    if (r_len == CNT_W'(1)) w_state_nxt = S_FLUSH;
                end else begin
`ifdef HYPER_MVBLCK_STALL_EN
                    w_state_nxt = S_STALL;
`else
                    w_state_nxt = S_FLUSH;
`endif
                end
            end
`ifdef HYPER_MVBLCK_STALL_EN
            S_STALL: begin
                if (!w_sel_empty) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (r_len == CNT_W'(1)) ? S_FLUSH : S_RUN;
                end else if (r_stall >= STALL_CW'(STALL_LIMIT - 1)) begin
                    w_state_nxt = S_FLUSH;
                end
            end
`endif
            S_FLUSH: begin
                if (r_fl == 2'd0 && r_mask != '0) w_flush_emit = 1'b1;
                if (r_fl == 2'd2) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_addr       <= '0;
            r_len        <= '0;
            r_cnt_req    <= '0;
            r_sect       <= '0;
            r_mask       <= '0;
            r_b_vld      <= 1'b0;
            r_b_addr     <= '0;
            r_b_we       <= '0;
            r_req        <= 1'b0;
            r_out_addr   <= '0;
            r_out_we     <= '0;
            r_read       <= 1'b0;
            r_working    <= 1'b0;
            r_done       <= 1'b0;
            r_count_sent <= '0;
            r_fl         <= 2'd0;
`ifdef HYPER_MVBLCK_STALL_EN
            r_stall      <= '0;
`endif
        end else begin
            r_read    <= w_accept;
            r_working <= (r_state != S_IDLE);
            r_done    <= w_done;
            if (w_done) r_count_sent <= r_cnt_req - r_len;

            if (w_latch) begin
                r_addr    <= START_ADDRESS;
                r_len     <= COUNT_REQ;
                r_cnt_req <= COUNT_REQ;
                r_sect    <= SECTION;
                r_mask    <= '0;
            end else if (w_accept) begin
                r_addr <= r_addr + 1'b1;
                r_len  <= r_len - 1'b1;
                r_mask <= w_close ? '0 : w_mask_nxt;
            end else if (w_flush_emit) begin
                r_mask <= '0;
            end

            // Two-stage request pipeline keeps address/WE stable under each request.
            r_b_vld <= (w_accept && w_close) || w_flush_emit;
            if ((w_accept && w_close) || w_flush_emit) begin
                r_b_addr <= w_base;
                r_b_we   <= w_accept ? w_mask_nxt : r_mask;
            end
            r_req <= r_b_vld;
            if (r_b_vld) begin
                r_out_addr <= r_b_addr;
                r_out_we   <= r_b_we;
            end

            r_fl <= (r_state == S_FLUSH) ? r_fl + 2'd1 : 2'd0;
`ifdef HYPER_MVBLCK_STALL_EN
            if (r_state == S_RUN)        r_stall <= STALL_CW'(1);
            else if (r_state == S_STALL) r_stall <= r_stall + 1'b1;
`endif
        end
    end

    assign LSAB_READ          = r_read;
    assign LSAB_SECTION       = r_sect;
    assign COUNT_SENT         = r_count_sent;
    assign WORKING            = r_working;
    assign DONE               = r_done;
    assign MCU_COLL_ADDRESS   = r_out_addr;
    assign MCU_WE_ARRAY       = r_out_we;
    assign MCU_REQUEST_ACCESS = r_req;

endmodule

`default_nettype wire

// File: tb/tb_hyper_mvblck_todram_gen.sv
// ============================================================================
// tb_hyper_mvblck_todram_gen : directed scoreboard bench for the LSAB-to-MCU
// transfer generator (default parameters).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hyper_mvblck_todram_gen;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  LSAB_EMPTY;
    logic        LSAB_READ;
    logic [1:0]  LSAB_SECTION;
    logic [11:0] START_ADDRESS;
    logic [4:0]  COUNT_REQ;
    logic [1:0]  SECTION;
    logic        ISSUE;
    logic [4:0]  COUNT_SENT;
    logic        WORKING;
    logic        DONE;
    logic [11:0] MCU_COLL_ADDRESS;
    logic [3:0]  MCU_WE_ARRAY;
    logic        MCU_REQUEST_ACCESS;

    hyper_mvblck_todram_gen dut (
        .CLK                (CLK),
        .RST                (RST),
        .LSAB_EMPTY         (LSAB_EMPTY),
        .LSAB_READ          (LSAB_READ),
        .LSAB_SECTION       (LSAB_SECTION),
        .START_ADDRESS      (START_ADDRESS),
        .COUNT_REQ          (COUNT_REQ),
        .SECTION            (SECTION),
        .ISSUE              (ISSUE),
        .COUNT_SENT         (COUNT_SENT),
        .WORKING            (WORKING),
        .DONE               (DONE),
        .MCU_COLL_ADDRESS   (MCU_COLL_ADDRESS),
        .MCU_WE_ARRAY       (MCU_WE_ARRAY),
        .MCU_REQUEST_ACCESS (MCU_REQUEST_ACCESS)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [11:0] a;
        logic [3:0]  we;
    } req_t;

    req_t exp_req[$];
    int   exp_cnt[$];
    int   exp_rd[$];
    int   total = 0;
    int   bad = 0;
    int   rd_cnt = 0;
    int   done_seen = 0;
    bit   working_seen = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void fail_ev(string name);
        total++;
        bad++;
        $display("FAIL %s: event occurred with nothing expected", name);
    endfunction

    function automatic void exp_r(logic [11:0] a, logic [3:0] we);
        req_t e;
        e.a  = a;
        e.we = we;
        exp_req.push_back(e);
    endfunction

    function automatic void exp_d(int cnt, int rd);
        exp_cnt.push_back(cnt);
        exp_rd.push_back(rd);
    endfunction

    // Monitor: pops and checks whenever the DUT presents a request or DONE.
    always @(negedge CLK) begin
        req_t e;
        if (RST) begin
            rd_cnt       = 0;
            working_seen = 1'b0;
        end else begin
            if (WORKING) working_seen = 1'b1;
            if (LSAB_READ) rd_cnt++;
            if (MCU_REQUEST_ACCESS) begin
                if (exp_req.size() == 0) begin
                    fail_ev("unexpected_request");
                end else begin
                    e = exp_req.pop_front();
                    chk("req_addr", 32'(MCU_COLL_ADDRESS), 32'(e.a));
                    chk("req_we", 32'(MCU_WE_ARRAY), 32'(e.we));
                end
            end
            if (DONE) begin
                if (exp_cnt.size() == 0) begin
                    fail_ev("unexpected_done");
                end else begin
                    chk("count_sent", 32'(COUNT_SENT), 32'(exp_cnt.pop_front()));
                    chk("read_cycles", 32'(rd_cnt), 32'(exp_rd.pop_front()));
                    chk("working_seen", 32'(working_seen), 32'd1);
                end
                rd_cnt       = 0;
                working_seen = 1'b0;
                done_seen++;
            end
        end
    end

    task automatic issue(input logic [11:0] a, input logic [4:0] c, input logic [1:0] s);
        START_ADDRESS = a;
        COUNT_REQ     = c;
        SECTION       = s;
        ISSUE         = 1'b1;
        @(negedge CLK);
        ISSUE         = 1'b0;
    endtask

    task automatic wait_done();
        int s = done_seen;
        int n = 0;
        while (done_seen == s && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (done_seen == s) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no DONE expected DONE within 200 cycles");
        end else begin
            @(negedge CLK);
            chk("working_idle", 32'(WORKING), 32'd0);
        end
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_read"}, 32'(LSAB_READ), 32'd0);
        chk({tag, "_section"}, 32'(LSAB_SECTION), 32'd0);
        chk({tag, "_count_sent"}, 32'(COUNT_SENT), 32'd0);
        chk({tag, "_working"}, 32'(WORKING), 32'd0);
        chk({tag, "_done"}, 32'(DONE), 32'd0);
        chk({tag, "_addr"}, 32'(MCU_COLL_ADDRESS), 32'd0);
        chk({tag, "_we"}, 32'(MCU_WE_ARRAY), 32'd0);
        chk({tag, "_req"}, 32'(MCU_REQUEST_ACCESS), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1);
    end

    initial begin
        LSAB_EMPTY    = 4'hF;
        START_ADDRESS = '0;
        COUNT_REQ     = '0;
        SECTION       = '0;
        ISSUE         = 1'b0;
        repeat (2) @(negedge CLK);
        chk_all_zero("reset");

        // Aligned 4-word transfer, ISSUE on the first edge after reset release.
        exp_r(12'h010, 4'b1111);
        exp_r(12'h012, 4'b1111);
        exp_d(4, 4);
        LSAB_EMPTY = 4'b1011;
        RST = 1'b0;
        issue(12'h010, 5'd4, 2'd2);
        chk("section_latched", 32'(LSAB_SECTION), 32'd2);
        wait_done();

        // Unaligned start while other sections' flags toggle.
        exp_r(12'h010, 4'b0011);
        exp_r(12'h012, 4'b1111);
        exp_d(3, 3);
        fork
            begin
                issue(12'h011, 5'd3, 2'd2);
                wait_done();
            end
            begin
                repeat (8) begin
                    @(negedge CLK);
                    LSAB_EMPTY = LSAB_EMPTY ^ 4'b1011;
                end
            end
        join
        LSAB_EMPTY = 4'b1011;
        @(negedge CLK);

        // Address wrap; a second ISSUE mid-transfer must be ignored.
        exp_r(12'hFFE, 4'b0011);
        exp_r(12'h000, 4'b1100);
        exp_d(2, 2);
        issue(12'hFFF, 5'd2, 2'd2);
        START_ADDRESS = 12'h100;
        COUNT_REQ     = 5'd9;
        ISSUE         = 1'b1;
        @(negedge CLK);
        ISSUE         = 1'b0;
        wait_done();

`ifdef HYPER_MVBLCK_STALL_EN
        // Section empty for 5 cycles, then data flows.
        exp_r(12'h020, 4'b1111);
        exp_r(12'h022, 4'b1111);
        exp_r(12'h024, 4'b1111);
        exp_r(12'h026, 4'b1111);
        exp_d(8, 8);
        LSAB_EMPTY = 4'b0010;
        issue(12'h020, 5'd8, 2'd1);
        repeat (4) @(negedge CLK);
        LSAB_EMPTY = 4'b0000;
        wait_done();
`else
        // Selected section empty from the start: nothing moves.
        exp_d(0, 0);
        LSAB_EMPTY = 4'b0001;
        issue(12'h020, 5'd8, 2'd0);
        wait_done();
`endif

        // Section runs dry after 3 words; open partial beat is flushed.
        exp_r(12'h000, 4'b1111);
        exp_r(12'h002, 4'b1100);
        exp_d(3, 3);
        LSAB_EMPTY = 4'b1011;
        issue(12'h000, 5'd8, 2'd2);
        repeat (3) @(negedge CLK);
        LSAB_EMPTY = 4'b1111;
        wait_done();

        // Zero-length command goes straight to completion.
        exp_d(0, 0);
        LSAB_EMPTY = 4'b1011;
        issue(12'h055, 5'd0, 2'd2);
        wait_done();

        // Asynchronous reset mid-transfer aborts with no DONE or request.
        issue(12'h040, 5'd8, 2'd2);
        @(negedge CLK);
        #2 RST = 1'b1;
        #1 chk_all_zero("midreset");
        repeat (2) @(negedge CLK);
        exp_r(12'h030, 4'b1111);
        exp_d(2, 2);
        RST = 1'b0;
        issue(12'h030, 5'd2, 2'd2);
        wait_done();

        repeat (4) @(negedge CLK);
        chk("req_queue_drained", 32'(exp_req.size()), 32'd0);
        chk("done_queue_drained", 32'(exp_cnt.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
